raster_scan_ctrl: RTL and testbench

RASTER_SCAN_CTRL -- requirements
Module: raster_scan_ctrl

---
 rtl/raster_scan_ctrl.sv | 141 ++++++++++++++
 tb/tb_raster_scan_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/raster_scan_ctrl.sv
// Raster scan controller: walks a triangle's clipped bounding box in SIZE x SIZE
// blocks, steering the edge-function accumulators and emitting a block stream.
module raster_scan_ctrl #(
    parameter int unsigned SIZE     = 2,
    parameter int unsigned SCREEN_W = 640,
    parameter int unsigned SCREEN_H = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tri_valid,
    output logic        tri_ready,
    input  logic [10:0] tri_xmin,
    input  logic [10:0] tri_xmax,
    input  logic [10:0] tri_ymin,
    input  logic [10:0] tri_ymax,
    input  logic [7:0]  tri_tag,
    output logic        ef_start,
    output logic        ef_row_end,
    output logic        blk_valid,
    output logic [10:0] blk_x,
    output logic [10:0] blk_y,
    output logic        blk_last,
    output logic [7:0]  blk_tag,
    output logic        busy
);

    localparam int unsigned SHIFT = $clog2(SIZE);
    localparam logic [10:0] X_LIM = 11'(SCREEN_W - 1);
    localparam logic [10:0] Y_LIM = 11'(SCREEN_H - 1);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] cur_bx_q, cur_bx_d;
    logic [10:0] cur_by_q, cur_by_d;
    logic [10:0] bx_min_q, bx_min_d;
    logic [10:0] bx_max_q, bx_max_d;
    logic [10:0] by_max_q, by_max_d;
    logic [7:0]  tag_q, tag_d;

    logic        blk_valid_q, blk_valid_d;
    logic [10:0] blk_x_q, blk_x_d;
    logic [10:0] blk_y_q, blk_y_d;
    logic        blk_last_q, blk_last_d;
    logic [7:0]  blk_tag_q, blk_tag_d;

    logic        last_blk;
    logic        tri_empty;
    logic [10:0] xmax_c;
    logic [10:0] ymax_c;

    always_comb begin
        last_blk   = (state_q == SCAN) && (cur_bx_q == bx_max_q) && (cur_by_q == by_max_q);
        tri_ready  = !rst && ((state_q == IDLE) || last_blk);
        ef_start   = tri_valid && tri_ready;
        ef_row_end = !rst && (state_q == SCAN) && (cur_bx_q == bx_max_q)
                     && (cur_by_q < by_max_q);
        busy       = (state_q == SCAN);

        xmax_c    = (tri_xmax > X_LIM) ? X_LIM : tri_xmax;
        ymax_c    = (tri_ymax > Y_LIM) ? Y_LIM : tri_ymax;
        tri_empty = (xmax_c < tri_xmin) || (ymax_c < tri_ymin);

        state_d  = state_q;
        cur_bx_d = cur_bx_q;
        cur_by_d = cur_by_q;
        bx_min_d = bx_min_q;
        bx_max_d = bx_max_q;
        by_max_d = by_max_q;
        tag_d    = tag_q;

        if (state_q == SCAN) begin
            if (last_blk) begin
                state_d = IDLE;
            end else if (cur_bx_q < bx_max_q) begin
                cur_bx_d = cur_bx_q + 11'd1;
            end else begin
                cur_bx_d = bx_min_q;
                cur_by_d = cur_by_q + 11'd1;
            end
        end

        // A non-empty handshake overrides the return to IDLE, so the next
        // triangle's first block follows the last block with no bubble.
        if (ef_start && !tri_empty) begin
            state_d  = SCAN;
            bx_min_d = tri_xmin >> SHIFT;
            bx_max_d = xmax_c >> SHIFT;
            by_max_d = ymax_c >> SHIFT;
            cur_bx_d = tri_xmin >> SHIFT;
            cur_by_d = tri_ymin >> SHIFT;
            tag_d    = tri_tag;
        end

        blk_valid_d = (state_q == SCAN);
        blk_x_d     = cur_bx_q << SHIFT;
        blk_y_d     = cur_by_q << SHIFT;
        blk_last_d  = last_blk;
        blk_tag_d   = tag_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_bx_q    <= '0;
            cur_by_q    <= '0;
            bx_min_q    <= '0;
            bx_max_q    <= '0;
            by_max_q    <= '0;
            tag_q       <= '0;
            blk_valid_q <= 1'b0;
            blk_x_q     <= '0;
            blk_y_q     <= '0;
            blk_last_q  <= 1'b0;
            blk_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            cur_bx_q    <= cur_bx_d;
            cur_by_q    <= cur_by_d;
            bx_min_q    <= bx_min_d;
            bx_max_q    <= bx_max_d;
            by_max_q    <= by_max_d;
            tag_q       <= tag_d;
            blk_valid_q <= blk_valid_d;
            blk_x_q     <= blk_x_d;
            blk_y_q     <= blk_y_d;
            blk_last_q  <= blk_last_d;
            blk_tag_q   <= blk_tag_d;
        end
    end

    assign blk_valid = blk_valid_q;
    assign blk_x     = blk_x_q;
    assign blk_y     = blk_y_q;
    assign blk_last  = blk_last_q;
    assign blk_tag   = blk_tag_q;

endmodule

// File: tb/tb_raster_scan_ctrl.sv
// Bench for raster_scan_ctrl: directed scenarios plus random triangles, checked
// against a queue of expected blocks built from the bounding-box rules.
module tb_raster_scan_ctrl;

    localparam int S = 2;
    localparam int W = 640;
    localparam int H = 480;

    logic        clk = 1'b0;
    logic        rst;
    logic        tri_valid;
    logic        tri_ready;
    logic [10:0] tri_xmin, tri_xmax, tri_ymin, tri_ymax;
    logic [7:0]  tri_tag;
    logic        ef_start, ef_row_end;
    logic        blk_valid;
    logic [10:0] blk_x, blk_y;
    logic        blk_last;
    logic [7:0]  blk_tag;
    logic        busy;

    always #5 clk = ~clk;

    raster_scan_ctrl #(.SIZE(S), .SCREEN_W(W), .SCREEN_H(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .tri_valid  (tri_valid),
        .tri_ready  (tri_ready),
        .tri_xmin   (tri_xmin),
        .tri_xmax   (tri_xmax),
        .tri_ymin   (tri_ymin),
        .tri_ymax   (tri_ymax),
        .tri_tag    (tri_tag),
        .ef_start   (ef_start),
        .ef_row_end (ef_row_end),
        .blk_valid  (blk_valid),
        .blk_x      (blk_x),
        .blk_y      (blk_y),
        .blk_last   (blk_last),
        .blk_tag    (blk_tag),
        .busy       (busy)
    );

    typedef struct {
        int x;
        int y;
        bit last;
        bit row_end;
        int tag;
    } blk_t;

    int   vectors = 0;
    int   miscompares = 0;
    blk_t acc_q[$];
    bit   ov = 0;
    int   ox = 0, oy = 0, otag = 0;
    bit   ol = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", name, got, exp);
        end
    endtask

    // Every block of the clipped box, row by row, in accumulator order.
    function automatic void push_tri(input int xmin, input int xmax, input int ymin,
                                     input int ymax, input int tg);
        int xc, yc;
        xc = (xmax > W - 1) ? W - 1 : xmax;
        yc = (ymax > H - 1) ? H - 1 : ymax;
        if (xc < xmin || yc < ymin) return;
        for (int by = ymin / S; by <= yc / S; by++) begin
            for (int bx = xmin / S; bx <= xc / S; bx++) begin
                blk_t b;
                b.x       = bx * S;
                b.y       = by * S;
                b.last    = (bx == xc / S) && (by == yc / S);
                b.row_end = (bx == xc / S) && (by != yc / S);
                b.tag     = tg;
                acc_q.push_back(b);
            end
        end
    endfunction

    task automatic step();
        bit ready_e, start_e, row_e, busy_e;
        @(negedge clk);
        if (rst) begin
            acc_q.delete();
            ov = 0; ox = 0; oy = 0; ol = 0; otag = 0;
        end
        busy_e  = !rst && (acc_q.size() > 0);
        ready_e = !rst && (acc_q.size() <= 1);
        start_e = ready_e && (tri_valid === 1'b1);
        row_e   = 0;
        if (busy_e) row_e = acc_q[0].row_end;

        check("tri_ready", 32'(tri_ready), 32'(ready_e));
        check("ef_start", 32'(ef_start), 32'(start_e));
        check("ef_row_end", 32'(ef_row_end), 32'(row_e));
        check("busy", 32'(busy), 32'(busy_e));
        check("blk_valid", 32'(blk_valid), 32'(ov));
        if (ov || rst) begin
            check("blk_x", 32'(blk_x), ox);
            check("blk_y", 32'(blk_y), oy);
            check("blk_last", 32'(blk_last), 32'(ol));
            check("blk_tag", 32'(blk_tag), otag);
        end

        if (!rst) begin
            if (acc_q.size() > 0) begin
                ov = 1; ox = acc_q[0].x; oy = acc_q[0].y;
                ol = acc_q[0].last; otag = acc_q[0].tag;
                void'(acc_q.pop_front());
            end else begin
                ov = 0;
            end
            if (start_e)
                push_tri(int'(tri_xmin), int'(tri_xmax), int'(tri_ymin),
                         int'(tri_ymax), int'(tri_tag));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_tri(input bit v, input int xmin, input int xmax, input int ymin,
                           input int ymax, input int tg);
        tri_valid = v;
        tri_xmin  = 11'(xmin);
        tri_xmax  = 11'(xmax);
        tri_ymin  = 11'(ymin);
        tri_ymax  = 11'(ymax);
        tri_tag   = 8'(tg);
    endtask

    initial begin
        int last_x;
        int xm, ym;
        rst = 1'b1;
        set_tri(0, 0, 0, 0, 0, 0);
        step();
        step();
        rst = 1'b0;

        // Six-block triangle with one row wrap
        set_tri(1, 1, 4, 2, 5, 8'h11);
        step();
        set_tri(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step();

        // Back-to-back single-block triangles
        set_tri(1, 0, 1, 0, 1, 8'h20);
        step();
        set_tri(1, 2, 3, 0, 1, 8'h21);
        step();
        set_tri(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step();

        // Empty triangle
        set_tri(1, 5, 3, 0, 1, 8'h30);
        step();
        set_tri(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step();

        // Right-edge clipping
        set_tri(1, 630, 2000, 0, 1, 8'h40);
        step();
        set_tri(0, 0, 0, 0, 0, 0);
        last_x = -1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (blk_valid === 1'b1 && blk_last === 1'b1) last_x = int'(blk_x);
        end
        check("clip_last_x", last_x, 638);

        // Reset during the third block, then immediate new triangle
        set_tri(1, 1, 4, 2, 5, 8'h50);
        step();
        set_tri(0, 0, 0, 0, 0, 0);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_tri(1, 8, 9, 8, 9, 8'h51);
        step();
        set_tri(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step();

        // Random traffic, including clipping, empties and occasional resets
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 79) == 0);
            xm = int'($urandom_range(0, 660));
            ym = int'($urandom_range(0, 490));
            set_tri($urandom_range(0, 2) == 0, xm, 0, ym, 0, int'($urandom_range(0, 255)));
            xm = xm + int'($urandom_range(0, 9)) - 2;
            ym = ym + int'($urandom_range(0, 7)) - 2;
            if (xm < 0) xm = 0;
            if (ym < 0) ym = 0;
            if ($urandom_range(0, 15) == 0) xm = 2047;
            if ($urandom_range(0, 15) == 0) ym = 2047;
            tri_xmax = 11'(xm);
            tri_ymax = 11'(ym);
            step();
        end
        rst = 1'b0;
        set_tri(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
